// File: rtl/ram_scan.sv
// Single-clock RAM: one write port, one direct read port and one auto-scan read port, cleared to INIT_VAL after reset.
// Both reads have 1-cycle latency; writes are dropped until ready; define RAM_SCAN_BYPASS_EN for write-first reads.
module ram_scan #(
   parameter int                DATA_W   = 4,
   parameter int                ADDR_W   = 5,
   parameter int                TICK_DIV = 50_000_000,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              scan_hold,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              ready
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] scan_data_q, scan_data_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      scan_addr_d = scan_addr_q;
      tick_d      = tick_q;
      rd_data_d   = '0;
      scan_data_d = '0;
      mem_we      = 1'b0;
      mem_waddr   = wr_addr;
      mem_wdata   = wr_data;

      case (state_q)
         INIT: begin
            // The clear sequencer owns the write port; user writes are dropped.
            mem_we      = 1'b1;
            mem_waddr   = ptr_q;
            mem_wdata   = INIT_VAL;
            ptr_d       = ptr_q + ADDR_W'(1);
            scan_addr_d = '0;
            tick_d      = '0;
            if (ptr_q == PTR_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            mem_we      = wr_en;
            rd_data_d   = mem_q[rd_addr];
            scan_data_d = mem_q[scan_addr_q];
`ifdef RAM_SCAN_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
               rd_data_d = wr_data;
            end
            if (wr_en && (wr_addr == scan_addr_q)) begin
               scan_data_d = wr_data;
            end
`endif
            if (!scan_hold) begin
               if (tick_q == TICK_LAST) begin
                  tick_d      = '0;
                  scan_addr_d = scan_addr_q + ADDR_W'(1);
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         scan_addr_q <= '0;
         tick_q      <= '0;
         rd_data_q   <= '0;
         scan_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         scan_addr_q <= scan_addr_d;
         tick_q      <= tick_d;
         rd_data_q   <= rd_data_d;
         scan_data_q <= scan_data_d;
      end
   end

   // Storage is not reset; the clear sequence rewrites every word instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_data   = rd_data_q;
   assign scan_data = scan_data_q;
   assign scan_addr = scan_addr_q;
   assign ready     = (state_q == RUN);

endmodule

// File: tb/tb_ram_scan.sv
// Randomised and directed bench for ram_scan with a word-array reference model.
module tb_ram_scan;

   localparam int DW    = 4;
   localparam int AW    = 5;
   localparam int TD    = 4;
   localparam int DEPTH = 32;
`ifdef RAM_SCAN_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          scan_hold;
   logic [AW-1:0] scan_addr;
   logic [DW-1:0] scan_data;
   logic          ready;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_ready;
   int            init_cnt;
   int            run_cnt;
   logic [DW-1:0] e_rd;
   logic [DW-1:0] e_scan;
   logic [AW-1:0] e_saddr;

   ram_scan #(.DATA_W(DW), .ADDR_W(AW), .TICK_DIV(TD), .INIT_VAL(4'h0)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .scan_hold(scan_hold), .scan_addr(scan_addr),
      .scan_data(scan_data), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_ready  = 1'b0;
      init_cnt = 0;
      run_cnt  = 0;
      e_rd     = '0;
      e_scan   = '0;
      e_saddr  = '0;
   endtask

   // One rising edge: the model applies the same inputs the DUT sees, then outputs settle.
   task automatic tick();
      @(posedge clk);
      if (reset_n) begin
         if (!m_ready) begin
            init_cnt++;
            if (init_cnt == DEPTH) begin
               m_ready = 1'b1;
               foreach (m_mem[i]) m_mem[i] = '0;
            end
         end else begin
            e_rd   = (BYPASS && wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
            e_scan = (BYPASS && wr_en && wr_addr == e_saddr) ? wr_data : m_mem[e_saddr];
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (!scan_hold) begin
               run_cnt++;
               e_saddr = AW'((run_cnt / TD) % DEPTH);
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; scan_hold = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
      total++; if (rd_data !== 4'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      total++; if (scan_data !== 4'h0) begin bad++; $display("FAIL reset_scan_data: got %h want 0", scan_data); end
      total++; if (scan_addr !== 5'd0) begin bad++; $display("FAIL reset_scan_addr: got %0d want 0", scan_addr); end
   endtask

   task automatic test_clear();
      reset_n = 1'b1;
      for (int e = 1; e <= DEPTH; e++) begin
         if (e == 5) begin wr_en = 1'b1; wr_addr = 5'd2; wr_data = 4'hF; end
         tick();
         wr_en = 1'b0;
         total++;
         if (ready !== (e == DEPTH)) begin
            bad++; $display("FAIL clear_ready edge %0d: got %b want %b", e, ready, e == DEPTH);
         end
         total++;
         if (rd_data !== 4'h0 || scan_addr !== 5'd0 || scan_data !== 4'h0) begin
            bad++; $display("FAIL clear_outputs edge %0d: got rd=%h sa=%0d sd=%h want 0", e, rd_data, scan_addr, scan_data);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         tick();
         total++;
         if (rd_data !== 4'h0) begin
            bad++; $display("FAIL clear_sweep addr %0d: got %h want 0", i, rd_data);
         end
      end
   endtask

   task automatic test_basic();
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 4'hC; tick();
      wr_addr = 5'd3; wr_data = 4'h8; tick();
      wr_en = 1'b0; rd_addr = 5'd1; tick();
      total++; if (rd_data !== 4'hC) begin bad++; $display("FAIL basic_addr1: got %h want c", rd_data); end
      rd_addr = 5'd3; tick();
      total++; if (rd_data !== 4'h8) begin bad++; $display("FAIL basic_addr3: got %h want 8", rd_data); end
   endtask

   task automatic test_read_during_write();
      logic [DW-1:0] first;
      first = BYPASS ? 4'h5 : 4'h0;
      rd_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 4'h5;
      tick();
      wr_en = 1'b0;
      total++; if (rd_data !== first) begin bad++; $display("FAIL rdw_first: got %h want %h", rd_data, first); end
      tick();
      total++; if (rd_data !== 4'h5) begin bad++; $display("FAIL rdw_second: got %h want 5", rd_data); end
   endtask

   task automatic test_scan_hold();
      logic [AW-1:0] prev;
      logic [AW-1:0] held;
      bit            saw_wrap;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'($urandom);
         tick();
      end
      wr_en = 1'b0;
      saw_wrap = 1'b0;
      prev = scan_addr;
      for (int c = 0; c < 140; c++) begin
         rd_addr = AW'($urandom);
         tick();
         total++;
         if (scan_addr !== e_saddr) begin bad++; $display("FAIL scan_addr cyc %0d: got %0d want %0d", c, scan_addr, e_saddr); end
         total++;
         if (scan_data !== e_scan) begin bad++; $display("FAIL scan_data cyc %0d: got %h want %h", c, scan_data, e_scan); end
         if (prev == 5'd31 && scan_addr == 5'd0) saw_wrap = 1'b1;
         prev = scan_addr;
      end
      total++; if (saw_wrap !== 1'b1) begin bad++; $display("FAIL scan_wrap: got %b want 1", saw_wrap); end
      held = e_saddr;
      scan_hold = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (scan_addr !== held) begin bad++; $display("FAIL scan_hold cyc %0d: got %0d want %0d", c, scan_addr, held); end
      end
      scan_hold = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = AW'($urandom);
         wr_data   = DW'($urandom);
         rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
         if ($urandom_range(0, 5) == 0) wr_addr = e_saddr;
         scan_hold = ($urandom_range(0, 7) == 0);
         tick();
         total++;
         if (rd_data !== e_rd || scan_data !== e_scan || scan_addr !== e_saddr || ready !== 1'b1) begin
            bad++;
            $display("FAIL random cyc %0d: got rd=%h sd=%h sa=%0d rdy=%b want rd=%h sd=%h sa=%0d rdy=1",
                     c, rd_data, scan_data, scan_addr, ready, e_rd, e_scan, e_saddr);
         end
      end
      wr_en = 1'b0; scan_hold = 1'b0;
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 4'hC; tick();
      wr_en = 1'b0; rd_addr = 5'd1; tick();
      total++; if (rd_data !== 4'hC) begin bad++; $display("FAIL mid_pre: got %h want c", rd_data); end
      reset_n = 1'b0;
      model_reset();
      #2;
      total++;
      if (ready !== 1'b0 || rd_data !== 4'h0 || scan_data !== 4'h0 || scan_addr !== 5'd0) begin
         bad++; $display("FAIL mid_async: got rdy=%b rd=%h sd=%h sa=%0d want all 0", ready, rd_data, scan_data, scan_addr);
      end
      #3;
      reset_n = 1'b1;
      for (int e = 1; e <= DEPTH; e++) begin
         tick();
         total++;
         if (ready !== (e == DEPTH)) begin bad++; $display("FAIL mid_ready edge %0d: got %b want %b", e, ready, e == DEPTH); end
      end
      rd_addr = 5'd1; tick();
      total++; if (rd_data !== 4'h0) begin bad++; $display("FAIL mid_cleared: got %h want 0", rd_data); end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_basic();
      test_read_during_write();
      test_scan_hold();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_scan.md
# ram_scan

Parametrised single-clock RAM with one write port, one direct registered read port and one auto-scanning read port, plus a hardware clear sequencer that initialises every word after reset. It replaces the fixed 32x4 board RAM in the lab top level. The scan port walks the address space at a programmable rate so the 7-segment display can cycle through memory contents without user input.

## Interface
- DATA_W, 4, word width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
- TICK_DIV, 50_000_000, clk cycles per scan-address step; must be >= 1
- INIT_VAL, 0, value written to every word during clear (DATA_W bits)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe; honoured only when ready=1
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  ADDR_W  direct read address
- rd_data  out  DATA_W  registered read data for rd_addr
- scan_hold  in  1  freezes the scan address and the tick counter
- scan_addr  out  ADDR_W  current scan address
- scan_data  out  DATA_W  registered read data for scan_addr
- ready  out  1  high once clear is complete

## Operation
- FSM states: INIT, RUN. Reset_n low forces INIT asynchronously.
- Reset values: ready=0, rd_data=0, scan_data=0, scan_addr=0, tick counter=0, init pointer=0.
- INIT: each cycle writes INIT_VAL to mem[ptr], ptr increments; after writing DEPTH-1, go to RUN. wr_en ignored. rd_data, scan_data, scan_addr, tick counter held at 0.
- RUN: ready=1. wr_en=1 writes wr_data to mem[wr_addr] at the clock edge.
- Direct read: every RUN cycle rd_data <= mem[rd_addr].
- Scan: tick counter counts 0..TICK_DIV-1. At terminal count, it returns to 0 and scan_addr increments, wrapping DEPTH-1 -> 0. scan_hold=1 holds both the counter and scan_addr. Every RUN cycle, scan_data <= mem[scan_addr].
- Read-during-write to the same address: behaviour set by the configuration macro (below). Applies independently to both read ports.
- Reset asserted mid-operation: all outputs return to reset values immediately. Memory contents are not preserved. The full INIT sequence reruns after release.

## Timing
- INIT lasts exactly DEPTH cycles after the first rising edge following reset_n release. ready rises on edge DEPTH (32 for the defaults).
- rd_data: 1-cycle latency from rd_addr.
- scan_data: 1-cycle latency from scan_addr change.
- scan_addr steps once every TICK_DIV cycles while not held. With TICK_DIV=1 it steps every cycle.
- A write is visible to a different-address read on the next edge, i.e. data appears 2 cycles after wr_en.

## Configuration
- RAM_SCAN_BYPASS_EN defined: when wr_en (RUN) and wr_addr equals rd_addr (or scan_addr), that port registers wr_data on the same edge (write-first).
- Not defined: that port registers the old memory word (read-first). The new value appears on the following cycle.

## Test plan
Bench parameters: DATA_W=4, ADDR_W=5, TICK_DIV=4, INIT_VAL=0.
- **Clear sequence:** release reset_n -> ready=0 for 32 edges, then 1; a sweep of all rd_addr 0..31 returns 0x0.
- **Ignored write during INIT:** wr_en=1, wr_addr=2, wr_data=0xF at edge 5 after release -> after ready, reading addr 2 gives 0x0.
- **Basic write/read:** write 0xC to addr 1, then 0x8 to addr 3 -> rd_addr=1 gives rd_data=0xC one cycle later; rd_addr=3 gives 0x8.
- **Read-during-write:** addr 7 holds 0x0; drive wr_addr=rd_addr=7, wr_data=0x5 for one cycle. Without the macro, rd_data=0x0 then 0x5; with RAM_SCAN_BYPASS_EN, rd_data=0x5 on the first edge.
- **Scan and hold:** scan_addr steps 0,1,2… every 4 cycles and wraps from 31 to 0; scan_data tracks mem[scan_addr] one cycle later; scan_hold=1 for 10 cycles leaves scan_addr unchanged.
- **Reset mid-run:** with addr 1=0xC, pulse reset_n low between edges -> outputs 0 immediately; INIT reruns for 32 cycles; addr 1 then reads 0x0.
